cos_lut_sched: RTL and testbench
================================

# cos_lut_sched

Scheduler and table owner for the shared 64-entry cosine LUT. It holds the 512-bit quarter-wave table and drives it onto the LUT's four 128-bit table inputs. It round-robin arbitrates up to NREQ requesters for one lookup per cycle and folds each requester's 8-bit full-circle phase onto the quarter-wave table. It returns a signed 9-bit cosine to the granted requester two cycles after acceptance.

## Interface
- NREQ, 4, number of requesters (2..8)
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- cfg_we  in  1  table write strobe
- cfg_addr  in  6  table entry to write
- cfg_data  in  8  unsigned entry value
- req  in  NREQ  per-requester lookup request, level
- req_phase  in  8*NREQ  phase of requester r in bits [8r+7:8r]; 256 steps per full circle
- gnt  out  NREQ  one-hot, combinational: request accepted this cycle
- rsp_valid  out  NREQ  one-hot, registered: rsp_data belongs to this requester
- rsp_data  out  9  signed two's-complement cosine, range -255..+255
- cos_index  out  6  index to LUT, registered
- cos_value  in  8  LUT output for cos_index
- cos_table1..cos_table4  out  128 each  entry k at cos_table(k/16+1)[(k%16)*8+7 : (k%16)*8]

## Operation
- Table: 64 x 8-bit registers.
  - cfg_we=1 writes cfg_data to entry cfg_addr at the clock edge.
  - Table outputs update the cycle after the edge.
- Arbitration (stage 0):
  - When cfg_we=0 and req≠0, grant exactly one requester, searching round-robin from last_gnt+1 upward with wrap.
  - last_gnt resets to NREQ-1, so requester 0 wins first.
  - While cfg_we=1: gnt=0, no acceptance; requests stay pending.
  - Requester may drop req or change phase after the gnt cycle. Holding req re-requests.
- Phase fold on accepted phase p: q=p[7:6], i=p[5:0].
  - q0: idx=i, positive.
  - q1: idx=64-i, negative.
  - q2: idx=i, negative.
  - q3: idx=64-i, positive.
  - If q is odd and i=0, force a zero result (flag zero). idx is then don't-care; drive 0.
- Stage 1 registers: cos_index=idx, neg, zero, and the one-hot id of the accepted requester.
- Stage 2 registers:
  - rsp_data = zero ? 0 : (neg ? -{1'b0,cos_value} : {1'b0,cos_value}), 9-bit arithmetic.
  - rsp_valid = stage-1 id if stage 1 is valid, else 0.
- Throughput: one lookup per cycle, fully pipelined, no stall. Requesters must accept rsp_valid when it appears.

## Timing
- Reset values:
  - gnt: 0 (no req).
  - rsp_valid: 0.
  - rsp_data: 0.
  - cos_index: 0.
  - stage-1 valid: 0.
  - last_gnt: NREQ-1.
  - Table: see Configuration.
- Latency: req accepted (gnt=1) in cycle N, then rsp_valid and rsp_data in cycle N+2 for exactly one cycle.
- Back-to-back: a different or same requester may be granted in N+1; its response arrives in N+3.
- Write and lookup collision: a stage-1 lookup reading the entry being written in the same cycle uses the old value. The new value is visible from the next cycle.
- Reset asserted mid-pipeline: in-flight lookups are discarded. rsp_valid=0 immediately (async), with no response after release.
- Single requester holding req: granted every cycle that cfg_we=0.

## Configuration
- COS_LUT_SCHED_DEFAULT_TABLE_EN
  - Defined: reset loads entry k = round(255·cos(k·π/128)), e.g. 255, 255, 255, 254, … entry 32 = 180 … entry 63 = 6.
  - Undefined: all entries reset to 0 and the table must be loaded through cfg_we before lookups are meaningful.
  - All other behaviour is identical.

## Test plan
- Macro defined, requester 0 phases 0, 63, 64, 96, 128, 224 on successive cycles: gnt each cycle, then rsp_data 255, 6, 0, -180, -255, +180 two cycles after each grant.
- All four req high continuously: gnt sequence 0, 1, 2, 3, 0, …; each rsp_valid one-hot matches its grant, delayed by 2 cycles.
- Write cfg_addr=32, cfg_data=100 while req[1] is high: gnt=0 that cycle. Next cycle phase 32 is granted and returns 100; cos_table3[7:0] reads 100.
- Macro undefined, after reset: phase 0 returns 0. Load entry 0 = 200, then phase 128 returns -200.
- Assert rst_n low the cycle after a grant: rsp_valid stays 0 through release, and the next grant goes to requester 0.
- Requester 2 drops req after one gnt: no further grants to it; other requesters continue rotating.

Source files
------------

// File: rtl/cos_lut_sched_if.sv
// Requester-side bundle for cos_lut_sched: level requests with per-requester
// phase, combinational one-hot grant, and registered one-hot response.
interface cos_lut_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_phase;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic signed [8:0] rsp_data;

    modport master (
        output req, req_phase,
        input  gnt, rsp_valid, rsp_data
    );

    modport slave (
        input  req, req_phase,
        output gnt, rsp_valid, rsp_data
    );
endinterface

// File: rtl/cos_lut_sched.sv
// Round-robin scheduler and quarter-wave table owner for the shared cosine LUT.
// Define COS_LUT_SCHED_DEFAULT_TABLE_EN to reset the table to a 255*cos ramp.
module cos_lut_sched #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    cos_lut_sched_if.slave  bus,
    input  logic            cfg_we,
    input  logic [5:0]      cfg_addr,
    input  logic [7:0]      cfg_data,
    output logic [5:0]      cos_index,
    input  logic [7:0]      cos_value,
    output logic [127:0]    cos_table1,
    output logic [127:0]    cos_table2,
    output logic [127:0]    cos_table3,
    output logic [127:0]    cos_table4
);
    localparam int IDW = $clog2(NREQ);

`ifdef COS_LUT_SCHED_DEFAULT_TABLE_EN
    // Entry k = round(255*cos(k*pi/128)); listed from entry 63 down to entry 0.
    localparam logic [63:0][7:0] TABLE_RST = {
        8'd6,   8'd13,  8'd19,  8'd25,  8'd31,  8'd37,  8'd44,  8'd50,
        8'd56,  8'd62,  8'd68,  8'd74,  8'd80,  8'd86,  8'd92,  8'd98,
        8'd103, 8'd109, 8'd115, 8'd120, 8'd126, 8'd131, 8'd136, 8'd142,
        8'd147, 8'd152, 8'd157, 8'd162, 8'd167, 8'd171, 8'd176, 8'd180,
        8'd185, 8'd189, 8'd193, 8'd197, 8'd201, 8'd205, 8'd208, 8'd212,
        8'd215, 8'd219, 8'd222, 8'd225, 8'd228, 8'd231, 8'd233, 8'd236,
        8'd238, 8'd240, 8'd242, 8'd244, 8'd246, 8'd247, 8'd249, 8'd250,
        8'd251, 8'd252, 8'd253, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255
    };
`else
    localparam logic [63:0][7:0] TABLE_RST = '0;
`endif

    // Returns {zero, neg, idx}; 6'd0 - i is 64-i modulo 64, which is 0 when i=0.
    function automatic logic [7:0] fold_phase(input logic [7:0] p);
        logic [1:0] q;
        logic [5:0] i;
        q = p[7:6];
        i = p[5:0];
        return {q[0] && (i == 6'd0), q[1] ^ q[0], q[0] ? (6'd0 - i) : i};
    endfunction

    function automatic logic signed [8:0] apply_sign(input logic [7:0] v,
                                                     input logic neg,
                                                     input logic zero);
        logic signed [8:0] mag;
        mag = $signed({1'b0, v});
        if (zero)
            return '0;
        return neg ? -mag : mag;
    endfunction

    logic [63:0][7:0] tbl;
    logic [IDW-1:0]   last_gnt;
    logic [IDW-1:0]   gidx;
    logic             found;
    logic             accept;
    logic [7:0]       fold_p0;
    logic             neg_p1;
    logic             zero_p1;
    logic             vld_p1;
    logic [NREQ-1:0]  id_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tbl <= TABLE_RST;
        else if (cfg_we)
            tbl[cfg_addr] <= cfg_data;
    end

    assign cos_table1 = tbl[15:0];
    assign cos_table2 = tbl[31:16];
    assign cos_table3 = tbl[47:32];
    assign cos_table4 = tbl[63:48];

    // Stage 0: round-robin search starting just after the last winner.
    always_comb begin
        int cand;
        cand  = 0;
        gidx  = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(last_gnt) + k;
            if (cand >= NREQ)
                cand = cand - NREQ;
            if (!found && bus.req[IDW'(cand)]) begin
                found = 1'b1;
                gidx  = IDW'(cand);
            end
        end
    end

    assign accept  = found && !cfg_we;
    assign fold_p0 = fold_phase(bus.req_phase[{gidx, 3'b000} +: 8]);

    always_comb begin
        bus.gnt = '0;
        if (accept)
            bus.gnt[gidx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_gnt <= IDW'(NREQ - 1);
        else if (accept)
            last_gnt <= gidx;
    end

    // Stage 1: folded index goes out to the LUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            id_p1     <= '0;
            cos_index <= '0;
            neg_p1    <= 1'b0;
            zero_p1   <= 1'b0;
        end else begin
            vld_p1 <= accept;
            id_p1  <= bus.gnt;
            if (accept) begin
                cos_index <= fold_p0[5:0];
                neg_p1    <= fold_p0[6];
                zero_p1   <= fold_p0[7];
            end
        end
    end

    // Stage 2: signed result back to the requester that was granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
        end else begin
            bus.rsp_valid <= vld_p1 ? id_p1 : '0;
            bus.rsp_data  <= apply_sign(cos_value, neg_p1, zero_p1);
        end
    end
endmodule

// File: tb/tb_cos_lut_sched.sv
// Directed bench for cos_lut_sched with a behavioural model of the external LUT.
module tb_cos_lut_sched;
    logic         clk;
    logic         rst_n;
    logic         cfg_we;
    logic [5:0]   cfg_addr;
    logic [7:0]   cfg_data;
    logic [5:0]   cos_index;
    logic [7:0]   cos_value;
    logic [127:0] cos_table1, cos_table2, cos_table3, cos_table4;
    logic [511:0] tbl_flat;

    int vectors;
    int miscompares;

`ifdef COS_LUT_SCHED_DEFAULT_TABLE_EN
    localparam int DEF0 = 255;
`else
    localparam int DEF0 = 0;
`endif

    cos_lut_sched_if #(.NREQ(4)) bus ();

    cos_lut_sched #(.NREQ(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cos_index  (cos_index),
        .cos_value  (cos_value),
        .cos_table1 (cos_table1),
        .cos_table2 (cos_table2),
        .cos_table3 (cos_table3),
        .cos_table4 (cos_table4)
    );

    assign tbl_flat  = {cos_table4, cos_table3, cos_table2, cos_table1};
    assign cos_value = tbl_flat[{cos_index, 3'b000} +: 8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] r, input logic [31:0] ph,
                        input logic we, input logic [5:0] a, input logic [7:0] d,
                        input logic [3:0] eg, input logic [3:0] ev, input int ed);
        @(posedge clk);
        #1;
        bus.req       = r;
        bus.req_phase = ph;
        cfg_we        = we;
        cfg_addr      = a;
        cfg_data      = d;
        @(negedge clk);
        chk({tag, "_gnt"}, bus.gnt, eg);
        chk({tag, "_vld"}, bus.rsp_valid, ev);
        if (ev != 4'd0)
            chk({tag, "_data"}, bus.rsp_data, ed);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.req_phase = '0;
        cfg_we        = 1'b0;
        cfg_addr      = '0;
        cfg_data      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_vld", bus.rsp_valid, 0);
        chk("rst_data", bus.rsp_data, 0);
        chk("rst_idx", cos_index, 0);
`ifdef COS_LUT_SCHED_DEFAULT_TABLE_EN
        chk("rst_tbl0", cos_table1[7:0], 255);
        chk("rst_tbl3", cos_table1[31:24], 254);
        chk("rst_tbl32", cos_table3[7:0], 180);
        chk("rst_tbl63", cos_table4[127:120], 6);
`else
        chk("rst_tbl_zero", tbl_flat[511:0] == 512'd0, 1);
`endif
        rst_n = 1'b1;

        // Reset table, then a write of entry 0 and its negated read-back.
        step("a_ph0",   4'h1, 32'd0,   1'b0, 6'd0,  8'd0,   4'h1, 4'h0, 0);
        step("a_idle",  4'h0, 32'd0,   1'b0, 6'd0,  8'd0,   4'h0, 4'h0, 0);
        step("a_rsp0",  4'h0, 32'd0,   1'b0, 6'd0,  8'd0,   4'h0, 4'h1, DEF0);
        step("a_wr0",   4'h0, 32'd0,   1'b1, 6'd0,  8'd200, 4'h0, 4'h0, 0);
        step("a_ph128", 4'h1, 32'd128, 1'b0, 6'd0,  8'd0,   4'h1, 4'h0, 0);
        step("a_idle2", 4'h0, 32'd0,   1'b0, 6'd0,  8'd0,   4'h0, 4'h0, 0);
        step("a_neg200",4'h0, 32'd0,   1'b1, 6'd0,  8'd255, 4'h0, 4'h1, -200);
        step("a_wr32",  4'h0, 32'd0,   1'b1, 6'd32, 8'd180, 4'h0, 4'h0, 0);
        step("a_wr63",  4'h0, 32'd0,   1'b1, 6'd63, 8'd6,   4'h0, 4'h0, 0);

        // Requester 0 walks the quadrant boundaries.
        step("b_p0",   4'h1, 32'd0,   1'b0, 6'd0, 8'd0, 4'h1, 4'h0, 0);
        chk("b_tbl63", cos_table4[127:120], 6);
        chk("b_tbl0", cos_table1[7:0], 255);
        step("b_p63",  4'h1, 32'd63,  1'b0, 6'd0, 8'd0, 4'h1, 4'h0, 0);
        step("b_p64",  4'h1, 32'd64,  1'b0, 6'd0, 8'd0, 4'h1, 4'h1, 255);
        step("b_p96",  4'h1, 32'd96,  1'b0, 6'd0, 8'd0, 4'h1, 4'h1, 6);
        step("b_p128", 4'h1, 32'd128, 1'b0, 6'd0, 8'd0, 4'h1, 4'h1, 0);
        step("b_p224", 4'h1, 32'd224, 1'b0, 6'd0, 8'd0, 4'h1, 4'h1, -180);
        step("b_t1",   4'h0, 32'd0,   1'b0, 6'd0, 8'd0, 4'h0, 4'h1, -255);
        step("b_t2",   4'h0, 32'd0,   1'b0, 6'd0, 8'd0, 4'h0, 4'h1, 180);
        step("b_t3",   4'h0, 32'd0,   1'b0, 6'd0, 8'd0, 4'h0, 4'h0, 0);

        // All four requesting; last winner was 0 so rotation starts at 1.
        step("c_1", 4'hF, {8'd224, 8'd128, 8'd63, 8'd0}, 1'b0, 6'd0, 8'd0, 4'h2, 4'h0, 0);
        step("c_2", 4'hF, {8'd224, 8'd128, 8'd63, 8'd0}, 1'b0, 6'd0, 8'd0, 4'h4, 4'h0, 0);
        step("c_3", 4'hF, {8'd224, 8'd128, 8'd63, 8'd0}, 1'b0, 6'd0, 8'd0, 4'h8, 4'h2, 6);
        step("c_4", 4'hF, {8'd224, 8'd128, 8'd63, 8'd0}, 1'b0, 6'd0, 8'd0, 4'h1, 4'h4, -255);
        step("c_5", 4'hF, {8'd224, 8'd128, 8'd63, 8'd0}, 1'b0, 6'd0, 8'd0, 4'h2, 4'h8, 180);
        step("c_6", 4'h0, 32'd0, 1'b0, 6'd0, 8'd0, 4'h0, 4'h1, 255);
        step("c_7", 4'h0, 32'd0, 1'b0, 6'd0, 8'd0, 4'h0, 4'h2, 6);
        step("c_8", 4'h0, 32'd0, 1'b0, 6'd0, 8'd0, 4'h0, 4'h0, 0);

        // Write blocks grants; write during a stage-1 read returns the old value.
        step("d_wr",   4'h2, {16'd0, 8'd32, 8'd0}, 1'b1, 6'd32, 8'd100, 4'h0, 4'h0, 0);
        step("d_gnt",  4'h2, {16'd0, 8'd32, 8'd0}, 1'b0, 6'd0,  8'd0,   4'h2, 4'h0, 0);
        chk("d_tbl32", cos_table3[7:0], 100);
        step("d_coll", 4'h0, 32'd0, 1'b1, 6'd32, 8'd180, 4'h0, 4'h0, 0);
        step("d_r100", 4'h0, 32'd0, 1'b0, 6'd0,  8'd0,   4'h0, 4'h2, 100);
        step("d_gnt2", 4'h2, {16'd0, 8'd32, 8'd0}, 1'b0, 6'd0, 8'd0, 4'h2, 4'h0, 0);
        step("d_idle", 4'h0, 32'd0, 1'b0, 6'd0,  8'd0,   4'h0, 4'h0, 0);
        step("d_r180", 4'h0, 32'd0, 1'b0, 6'd0,  8'd0,   4'h0, 4'h2, 180);

        // Requester 2 leaves after one grant; 0 and 3 keep rotating.
        step("e_1", 4'hD, 32'd0, 1'b0, 6'd0, 8'd0, 4'h4, 4'h0, 0);
        step("e_2", 4'h9, 32'd0, 1'b0, 6'd0, 8'd0, 4'h8, 4'h0, 0);
        step("e_3", 4'h9, 32'd0, 1'b0, 6'd0, 8'd0, 4'h1, 4'h4, 255);
        step("e_4", 4'h9, 32'd0, 1'b0, 6'd0, 8'd0, 4'h8, 4'h8, 255);
        step("e_5", 4'h9, 32'd0, 1'b0, 6'd0, 8'd0, 4'h1, 4'h1, 255);
        step("e_6", 4'h0, 32'd0, 1'b0, 6'd0, 8'd0, 4'h0, 4'h8, 255);
        step("e_7", 4'h0, 32'd0, 1'b0, 6'd0, 8'd0, 4'h0, 4'h1, 255);
        step("e_8", 4'h0, 32'd0, 1'b0, 6'd0, 8'd0, 4'h0, 4'h0, 0);

        // Reset one cycle after a grant discards it and restarts rotation at 0.
        step("f_gnt", 4'h2, 32'd0, 1'b0, 6'd0, 8'd0, 4'h2, 4'h0, 0);
        @(posedge clk);
        #1;
        bus.req = '0;
        rst_n   = 1'b0;
        #1;
        chk("f_rst_vld", bus.rsp_valid, 0);
        chk("f_rst_idx", cos_index, 0);
        @(posedge clk);
        #1;
        chk("f_rst_vld2", bus.rsp_valid, 0);
        rst_n = 1'b1;
        step("f_post1", 4'h0, 32'd0, 1'b0, 6'd0, 8'd0, 4'h0, 4'h0, 0);
        step("f_rr0",   4'hF, 32'd0, 1'b0, 6'd0, 8'd0, 4'h1, 4'h0, 0);
        step("f_idle",  4'h0, 32'd0, 1'b0, 6'd0, 8'd0, 4'h0, 4'h0, 0);
        step("f_rsp",   4'h0, 32'd0, 1'b0, 6'd0, 8'd0, 4'h0, 4'h1, DEF0);
        step("f_end",   4'h0, 32'd0, 1'b0, 6'd0, 8'd0, 4'h0, 4'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
